// File: rtl/ram_seq_pkg.sv
// Shared types and defaults for the sequence RAM read master.
package ram_seq_pkg;

    localparam int RSR_ADDR_W = 4;
    localparam int RSR_DATA_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_READ = 3'd2,
        ST_SHOW = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/ram_seq_reader.sv
// Walks a circular RAM address range and hands each word downstream
// over valid/ready, with optional looping and abort.
module ram_seq_reader
    import ram_seq_pkg::*;
#(
    parameter int ADDR_W = RSR_ADDR_W,
    parameter int DATA_W = RSR_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic              loop,
    input  logic              abort,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              busy,
    output logic              done
);

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] first_q;
    logic [ADDR_W-1:0] last_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;
    logic              hs;

    assign hs = valid_q && data_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        first_q <= first_addr;
                        last_q  <= last_addr;
                        ptr_q   <= first_addr;
                        busy_q  <= 1'b1;
                        state_q <= ST_ADDR;
                    end
                end
                ST_ADDR: state_q <= ST_READ;
                ST_READ: begin
                    data_q  <= ram_q;
                    valid_q <= 1'b1;
                    state_q <= ST_SHOW;
                end
                ST_SHOW: begin
                    if (hs) begin
                        valid_q <= 1'b0;
                        if (ptr_q != last_q) begin
                            ptr_q   <= ptr_q + 1'b1;
                            state_q <= ST_ADDR;
                        end else if (loop) begin
                            ptr_q   <= first_q;
                            state_q <= ST_ADDR;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
            // abort wins over any handshake taken in the same cycle
            if (abort && state_q != ST_IDLE) begin
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
                state_q <= ST_IDLE;
            end
        end
    end

    assign ram_addr   = ptr_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/ram_seq_reader.md
# ram_seq_reader

Sequencing read master for the 16x4 synchronous RAM, which has a registered address and a 1-cycle read latency. On `start` it walks a circular address range `first_addr`..`last_addr`, wrapping 15→0 when needed. It fetches each 4-bit entry and delivers it downstream over a valid/ready handshake, with optional continuous looping and abort. It sits between the sequence RAM and the consumer logic, the drone command/display path. The RAM write port stays with the parent; this block only reads.

## Interface

Parameters:
- `ADDR_W`, default 4: RAM address width; the range wraps modulo 2^ADDR_W.
- `DATA_W`, default 4: RAM word width.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: synchronous reset, active-low.
- `start` input 1: begin playback; sampled only in IDLE.
- `first_addr` input ADDR_W: first entry; captured on accepted `start`.
- `last_addr` input ADDR_W: last entry; captured on accepted `start`.
- `loop` input 1: replay from `first_addr` after `last_addr`; sampled live at each last handshake.
- `abort` input 1: terminate playback.
- `ram_addr` output ADDR_W: connects to the RAM `addr` input.
- `ram_q` input DATA_W: connects to the RAM `q` output.
- `data_out` output DATA_W: registered entry.
- `data_valid` output 1: `data_out` holds an undelivered entry.
- `data_ready` input 1: consumer accepts when high together with `data_valid`.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse at the end of a non-looped pass.

## Operation

- **States:** IDLE, ADDR, READ, SHOW, DONE.
- **IDLE:**
  - `start=1` captures `first_addr` and `last_addr`, sets ptr=`first_addr`, then goes to ADDR.
  - `start` in any other state is ignored.
- **ADDR:** `ram_addr`=ptr, so the RAM registers the address at the end of this cycle. Next state is READ.
- **READ:**
  - `ram_q` is valid and equals RAM[ptr]; it is latched into `data_out` at the end of the cycle.
  - Next state is SHOW.
- **SHOW:** `data_valid`=1 and `data_out` is held stable until handshake.
  - Handshake with ptr≠last: ptr=ptr+1 (mod 2^ADDR_W), next state ADDR.
  - Handshake with ptr=last and `loop`=1: ptr=first, next state ADDR.
  - Handshake with ptr=last and `loop`=0: next state DONE.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- **Range arithmetic:**
  - Entry count = ((last−first) mod 2^ADDR_W) + 1.
  - first=last gives one entry. last<first wraps through the top address.
- `ram_addr` equals ptr in every state; the value matters only in ADDR.
- **abort** (any non-IDLE state) goes to IDLE next cycle.
  - `data_valid` drops that same next cycle, and `done` is not pulsed.
  - abort has priority over a simultaneous handshake: the entry counts as delivered, but the sequence still stops.
- **Reset:**
  - `reset_n`=0 at any clock edge, including mid-pass, gives IDLE.
  - Reset values: ptr=0, `ram_addr`=0, `data_out`=0, `data_valid`=0, `busy`=0, `done`=0.
  - Captured first/last are cleared to 0.

## Timing

- `start` sampled at edge 0 gives ADDR in cycle 1, READ in cycle 2, and `data_valid`=1 from cycle 3.
- With `data_ready` held high: one entry per 3 cycles, with `data_valid` high in cycles 3, 6, 9, ….
- `done` is high in the cycle after the final handshake cycle.
- `busy` is high from the cycle after `start` through the DONE cycle inclusive.
- Back-to-back: `start` is sampled again in the cycle after DONE at the earliest.
- `data_out` changes only at the end of READ. It is never modified while `data_valid`=1.

## Structure

- A shared package `ram_seq_pkg` holds:
  - the state encoding constants (IDLE=0, ADDR=1, READ=2, SHOW=3, DONE=4; 3-bit);
  - `ADDR_W`/`DATA_W` defaults.
- There is no sub-module: one FSM plus pointer/output registers.
- The RAM is instantiated by the parent, with `we` driven by the parent's writer.

## Test plan

Common bench setup:
- The bench instantiates the 16x4 RAM at its power-up contents: 0:0001, 1:1010, 2:0010, 3:0100, 14:0100, 15:0101.
- Every scenario that requires `reset_n`=1 except at asserted reset must also clear `data_valid` on reset.

Scenarios:
1. **Reset:** hold `reset_n`=0 for 2 cycles with `start`=1 → every output is 0 and `busy` stays 0.
2. **Basic pass:**
   - Stimulus: `first`=0, `last`=3, `ready`=1, `start` pulse at cycle 0.
   - Response: `data_out` 0001, 1010, 0010, 0100 valid in cycles 3, 6, 9, 12.
   - Response: `done` high in cycle 13 only, `busy` low from cycle 14.
3. **Wrap:** `first`=14, `last`=1 → sequence 0100, 0101, 0001, 1010 then `done`; `ram_addr` goes 14, 15, 0, 1.
4. **Backpressure:**
   - Stimulus: range 0..1, `ready` low for 5 cycles after the first `data_valid`.
   - Response: 0001 is held stable with `data_valid`=1 for 6 cycles; 1010 follows 3 cycles after the accepting edge.
5. **Loop/abort:**
   - Stimulus: range 2..3 with `loop`=1.
   - Response: 0010, 0100, 0010, … repeats with no `done`.
   - Stimulus: `abort` asserted in a SHOW cycle with `ready`=1.
   - Response: IDLE next cycle, `data_valid`=0, no `done`.
6. **Reset mid-pass / start ignored:**
   - Stimulus: `start` while `busy` with new first/last → no effect on the running sequence.
   - Stimulus: `reset_n`=0 during READ → all outputs 0 next cycle; a fresh `start` restarts cleanly.
